reset_seq: RTL and testbench
============================

# reset_seq

Parametrised reset sequencer for the system clock domain. It synchronises and filters the PLL lock indication, then releases `N_CH` active-low reset outputs in a fixed order with a programmable gap between channels. A single-cycle software reset request re-runs the sequence without waiting for lock again. It sits directly after clock generation and drives the per-subsystem resets (core, memory, audio front-end, etc.) in place of a fixed-depth reset shift register.

## Interface
- `N_CH`, 3: number of sequenced reset outputs; ≥1.
- `SYNC_STAGES`, 2: synchroniser depth on `i_pll_locked`; ≥2.
- `LOCK_CYCLES`, 8: consecutive synchronised-lock cycles required before release; ≥1.
- `GAP_CYCLES`, 4: cycles between release of channel k-1 and channel k; ≥1.
- `SW_RST_CYCLES`, 16: hold time of a software-initiated reset; ≥1.

- `i_clk`  in  1  system clock.
- `i_rst_n`  in  1  reset. Asynchronous assert, active-low; release is synchronous to `i_clk` externally.
- `i_pll_locked`  in  1  PLL lock. Asynchronous to `i_clk`; synchronised internally.
- `i_sw_rst`  in  1  software reset request. Synchronous, sampled high on a single edge.
- `o_rst_n`  out  N_CH  per-channel reset, active-low. Bit 0 releases first.
- `o_ready`  out  1  high when all channels are released (state RUN).

## Operation
- While `i_rst_n` is low:
  - all `o_rst_n` = 0, `o_ready` = 0;
  - synchroniser flops = 0, counters = 0, state = HOLD.
- All outputs come from registers; no combinational path from any input to any output.
- States: HOLD, RELEASE, RUN, SWRST.
- HOLD:
  - all channels asserted.
  - Lock counter increments on each edge with `lock_s`=1 and clears on any edge with `lock_s`=0.
  - On the `LOCK_CYCLES`-th consecutive edge with `lock_s`=1: go to RELEASE, set `o_rst_n[0]`=1, channel index = 1, clear gap counter.
  - `i_sw_rst` is ignored.
- RELEASE:
  - Gap counter counts edges.
  - On the `GAP_CYCLES`-th edge: set `o_rst_n[index]`=1, increment index, clear gap counter.
  - The edge that releases channel `N_CH-1` also sets `o_ready`=1 and enters RUN.
  - If `N_CH`=1: HOLD goes straight to RUN, and `o_ready` rises with `o_rst_n[0]`.
- RUN: holds all channels released.
- Lock loss (`lock_s`=0 in RELEASE, RUN or SWRST):
  - next edge sets all `o_rst_n`=0 and `o_ready`=0, and enters HOLD with counters cleared.
  - Lock loss has priority over `i_sw_rst`.
- `i_sw_rst`=1 in RELEASE or RUN (with `lock_s`=1):
  - next edge sets all `o_rst_n`=0 and `o_ready`=0, and enters SWRST with counter cleared.
- SWRST:
  - counts edges; on the `SW_RST_CYCLES`-th edge, enters RELEASE exactly as from HOLD (`o_rst_n[0]`=1 on that edge).
  - The lock filter is not re-run.
  - `i_sw_rst` is ignored in SWRST; it does not restart the count.
- Channels never release out of order. Once a channel is released, it is asserted again only by lock loss, `i_sw_rst`, or `i_rst_n`.

## Timing
- Synchroniser: `i_pll_locked` sampled at edge n appears on `lock_s` after edge n+`SYNC_STAGES`-1. The FSM first acts on it at edge n+`SYNC_STAGES`.
- Lock rise: if `i_pll_locked` is first sampled high at edge E0, `o_rst_n[0]` rises after edge E(`SYNC_STAGES`+`LOCK_CYCLES`-1).
- Release spacing: `o_rst_n[k]` rises `k`·`GAP_CYCLES` edges after `o_rst_n[0]`. `o_ready` rises on the same edge as the last channel.
- Lock loss: `i_pll_locked` first sampled low at edge F0 drops all outputs after edge F(`SYNC_STAGES`).
- Software reset: `i_sw_rst` sampled at G0 drops all outputs after G0. `o_rst_n[0]` rises after G(`SW_RST_CYCLES`).
- Counter widths: `$clog2(max(LOCK_CYCLES, GAP_CYCLES, SW_RST_CYCLES)+1)`. Index width: `$clog2(N_CH+1)`. Counters saturate and never wrap.

## Structure
- `reset_seq_pkg`: state enum `rst_state_e` {HOLD, RELEASE, RUN, SWRST}; a width helper function for counter sizing.
- Sub-module `sync_ff`:
  - parametrised `STAGES`, single bit;
  - async active-low clear to 0;
  - instantiated once for `i_pll_locked`.
- FSM, counters and output register live in `reset_seq`.

## Test plan
Configuration for all scenarios: `N_CH`=3, `SYNC_STAGES`=2, `LOCK_CYCLES`=8, `GAP_CYCLES`=4, `SW_RST_CYCLES`=16.

1. Lock high from E0 → `o_rst_n`=001 after E9, 011 after E13, 111 and `o_ready`=1 after E17; all outputs 0 before E9.
2. Lock high 5 cycles, low 1 cycle, then high from E0 → no release until after E9 (filter restarts); no earlier partial release.
3. In RUN, lock low sampled at F0 → `o_rst_n`=000 and `o_ready`=0 after F2. Lock restored → full sequence per scenario 1 timing.
4. In RUN, `i_sw_rst` pulse at G0 → 000 after G0, 001 after G16, 011 after G20, 111 after G24. A second pulse at G5 has no effect.
5. `i_sw_rst` and lock loss together → lock-loss behaviour (HOLD; the lock filter must be re-satisfied).
6. `i_rst_n` low mid-RELEASE (`o_rst_n`=011) → outputs 000 immediately (asynchronous). After release, the full scenario 1 latency is measured from the first lock sample.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    SWRST   = 2'd3
  } rst_state_e;

  // One counter serves the lock filter, the release gap and the sw hold time,
  // so it is sized for the largest of the three.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_seq_sync.sv
// Single-bit multi-flop synchroniser with asynchronous active-low clear.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], i_d};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sync_q <= '0;
    else          sync_q <= sync_d;
  end

  assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/reset_seq.sv
// Reset sequencer: filters PLL lock, then releases N_CH active-low resets in
// order with a fixed gap; a software pulse replays the release without refiltering.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int N_CH          = 3,
  parameter int SYNC_STAGES   = 2,
  parameter int LOCK_CYCLES   = 8,
  parameter int GAP_CYCLES    = 4,
  parameter int SW_RST_CYCLES = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_pll_locked,
  input  logic            i_sw_rst,
  output logic [N_CH-1:0] o_rst_n,
  output logic            o_ready
);

  localparam int CW = cnt_width(LOCK_CYCLES, GAP_CYCLES, SW_RST_CYCLES);
  localparam int IW = $clog2(N_CH + 1);

  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] SW_LAST   = CW'(SW_RST_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_CH - 1);

  logic lock_s;

  sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_pll_locked),
    .o_q     (lock_s)
  );

  rst_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [IW-1:0]   idx_q, idx_d;
  logic [N_CH-1:0] rst_n_q, rst_n_d;
  logic            ready_q, ready_d;
  logic            start_release;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    rst_n_d       = rst_n_q;
    ready_d       = ready_q;
    start_release = 1'b0;

    unique case (state_q)
      HOLD: begin
        if (!lock_s)                 cnt_d = '0;
        else if (cnt_q == LOCK_LAST) start_release = 1'b1;
        else                         cnt_d = cnt_inc;
      end
      RELEASE: begin
        if (cnt_q == GAP_LAST) begin
          for (int k = 0; k < N_CH; k++)
            if (IW'(k) == idx_q) rst_n_d[k] = 1'b1;
          idx_d = idx_q + IW'(1);
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = RUN;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      SWRST: begin
        if (cnt_q == SW_LAST) start_release = 1'b1;
        else                  cnt_d = cnt_inc;
      end
      RUN: ;
    endcase

    // Channel 0 goes out on the same edge the filter or sw hold completes.
    if (start_release) begin
      rst_n_d    = '0;
      rst_n_d[0] = 1'b1;
      idx_d      = IW'(1);
      cnt_d      = '0;
      if (N_CH == 1) begin
        state_d = RUN;
        ready_d = 1'b1;
      end else begin
        state_d = RELEASE;
      end
    end

    // Lock loss overrides everything, including a concurrent sw request.
    if (state_q != HOLD && !lock_s) begin
      state_d = HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      rst_n_d = '0;
      ready_d = 1'b0;
    end else if ((state_q == RELEASE || state_q == RUN) && i_sw_rst) begin
      state_d = SWRST;
      cnt_d   = '0;
      idx_d   = '0;
      rst_n_d = '0;
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      ready_q <= ready_d;
    end
  end

  assign o_rst_n = rst_n_q;
  assign o_ready = ready_q;

endmodule

// File: tb/tb_reset_seq.sv
// Bench for reset_seq: directed scenarios plus random lock/sw traffic against
// an anchor-based timing model of the release schedule.
module tb_reset_seq;

  localparam int N_CH = 3;
  localparam int SYNC = 2;
  localparam int LOCK = 8;
  localparam int GAP  = 4;
  localparam int SWC  = 16;

  logic            gclk   = 1'b0;
  logic            grst_n = 1'b0;
  logic            pll    = 1'b0;
  logic            sw     = 1'b0;
  logic [N_CH-1:0] rst_n;
  logic            ready;

  int tests = 0;
  int fails = 0;

  always #5 gclk = ~gclk;

  reset_seq #(
    .N_CH          (N_CH),
    .SYNC_STAGES   (SYNC),
    .LOCK_CYCLES   (LOCK),
    .GAP_CYCLES    (GAP),
    .SW_RST_CYCLES (SWC)
  ) dut (
    .i_clk        (gclk),
    .i_rst_n      (grst_n),
    .i_pll_locked (pll),
    .i_sw_rst     (sw),
    .o_rst_n      (rst_n),
    .o_ready      (ready)
  );

  // Model: a release sequence is an "anchor" edge where channel 0 goes out;
  // channel k follows k*GAP edges later. Lock loss cancels it, sw moves it.
  bit              hist[$];
  int              e;
  bit              seq_on;
  int              run;
  int              anchor;
  logic [N_CH-1:0] m_rst;
  logic            m_rdy;

  task automatic model_reset();
    hist.delete();
    e      = 0;
    seq_on = 1'b0;
    run    = 0;
    anchor = 0;
    m_rst  = '0;
    m_rdy  = 1'b0;
  endtask

  task automatic model_edge(input bit p, input bit s);
    bit ls;
    ls = (e >= SYNC) ? hist[e - SYNC] : 1'b0;
    hist.push_back(p);
    if (!seq_on) begin
      run = ls ? run + 1 : 0;
      if (run == LOCK) begin
        seq_on = 1'b1;
        anchor = e;
        run    = 0;
      end
    end else if (!ls) begin
      seq_on = 1'b0;
      run    = 0;
    end else if (s && e > anchor) begin
      anchor = e + SWC;
    end
    for (int k = 0; k < N_CH; k++) m_rst[k] = seq_on && (e >= anchor + k * GAP);
    m_rdy = seq_on && (e >= anchor + (N_CH - 1) * GAP);
    e++;
  endtask

  task automatic check(input string tag, input logic [N_CH:0] obs, input logic [N_CH:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got {rdy,rst_n}=%b want %b", tag, obs, exp);
    end
  endtask

  task automatic step(input bit p, input bit s);
    pll = p;
    sw  = s;
    @(posedge gclk);
    model_edge(p, s);
    #1 check("model", {ready, rst_n}, {m_rdy, m_rst});
  endtask

  task automatic do_reset(input string tag);
    #2 grst_n = 1'b0;
    sw = 1'b0;
    #1 check(tag, {ready, rst_n}, '0);
    model_reset();
    repeat (3) @(posedge gclk);
    #1 check({tag, "_held"}, {ready, rst_n}, '0);
    @(negedge gclk);
    grst_n = 1'b1;
  endtask

  // Lock held high from E0 (step i is edge Ei); checks the nominal release points.
  task automatic lock_up(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0);
      if (i == 8)  check({tag, "_e8"},  {ready, rst_n}, 4'b0000);
      if (i == 9)  check({tag, "_e9"},  {ready, rst_n}, 4'b0001);
      if (i == 12) check({tag, "_e12"}, {ready, rst_n}, 4'b0001);
      if (i == 13) check({tag, "_e13"}, {ready, rst_n}, 4'b0011);
      if (i == 16) check({tag, "_e16"}, {ready, rst_n}, 4'b0011);
      if (i == 17) check({tag, "_e17"}, {ready, rst_n}, 4'b1111);
    end
  endtask

  initial begin
    bit cur;
    model_reset();

    // 1: clean lock-up
    do_reset("rst0");
    lock_up("s1", 18);

    // 2: short lock glitch restarts the filter
    do_reset("rst2");
    repeat (5) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    lock_up("s2", 18);

    // 3: lock loss in RUN, then recovery
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      if (i == 1) check("s3_f1", {ready, rst_n}, 4'b1111);
      if (i == 2) check("s3_f2", {ready, rst_n}, 4'b0000);
    end
    lock_up("s3r", 18);

    // 4: software reset, second pulse during hold ignored
    for (int i = 0; i < 25; i++) begin
      step(1'b1, (i == 0) || (i == 5));
      if (i == 0)  check("s4_g0",  {ready, rst_n}, 4'b0000);
      if (i == 15) check("s4_g15", {ready, rst_n}, 4'b0000);
      if (i == 16) check("s4_g16", {ready, rst_n}, 4'b0001);
      if (i == 19) check("s4_g19", {ready, rst_n}, 4'b0001);
      if (i == 20) check("s4_g20", {ready, rst_n}, 4'b0011);
      if (i == 24) check("s4_g24", {ready, rst_n}, 4'b1111);
    end

    // 5: sw request on the edge lock loss reaches the FSM -> lock filter path
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("s5_f1", {ready, rst_n}, 4'b1111);
    for (int i = 2; i < 21; i++) begin
      step(1'b1, i == 2);
      if (i == 2)  check("s5_f2",  {ready, rst_n}, 4'b0000);
      if (i == 9)  check("s5_f9",  {ready, rst_n}, 4'b0000);
      if (i == 10) check("s5_f10", {ready, rst_n}, 4'b0001);
      if (i == 18) check("s5_f18", {ready, rst_n}, 4'b1111);
    end

    // 6: async reset mid-release, then full latency again
    do_reset("rst6");
    lock_up("s6a", 14);
    check("s6_mid", {ready, rst_n}, 4'b0011);
    do_reset("s6_async");
    lock_up("s6b", 18);

    // Random traffic: long lock runs with short dropouts, sparse sw pulses
    cur = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset("rnd_rst");
      if (cur) begin
        if ($urandom_range(0, 99) < 3) cur = 1'b0;
      end else begin
        if ($urandom_range(0, 99) < 35) cur = 1'b1;
      end
      step(cur, $urandom_range(0, 99) < 3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
